mem_responder: RTL
==================

Name: mem_responder

Overview:
- Bus target at the far end of the core's memory interface: services core instruction fetches, loads and stores.
- Contains a word-organised RAM and a memory-mapped machine timer (mtime/mtimecmp).
- Drives the timer interrupt back toward the core's CSR block.
- Read data is registered: one cycle of latency, which the multi-cycle core control sequence absorbs.

Parameters:
- DEPTH, 1024, RAM size in 32-bit words; RAM decodes byte addresses 0 to DEPTH*4-1.
- MMIO_BASE, 32'hFFFF0000, base byte address of the timer registers.
- TICK_DIV, 1, number of clk cycles per mtime increment; must be >= 1.
- INIT_FILE, "", hex file loaded into RAM at elaboration; empty means the RAM is not loaded.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- bus_addr  in  32  byte address from the core.
- bus_wdata  in  32  store data, right-justified: byte in [7:0], half in [15:0].
- bus_read_en  in  1  read request this cycle.
- bus_write_en  in  1  write request this cycle.
- bus_width  in  2  access width: 0 byte, 1 half, 2 word, 3 illegal.
- bus_rdata  out  32  registered read data, right-justified and zero-extended.
- bus_error  out  1  registered; high for one cycle after a faulting access.
- timer_irq  out  1  registered machine timer interrupt, level.

Behaviour:
- Reset (reset==0, asynchronous):
  - bus_rdata=0, bus_error=0, timer_irq=0.
  - mtime=0, mtimecmp=64'hFFFFFFFF_FFFFFFFF, prescaler count=0.
  - RAM contents are not cleared.
  - A reset asserted mid-access aborts that access: no RAM write occurs on a reset edge.
- Request sampling: requests are sampled on the rising edge of clk. Results appear on bus_rdata and bus_error the following cycle.
- Holding: bus_rdata holds its value in any cycle with no read. bus_error clears to 0 on any non-faulting cycle.
- Alignment:
  - Half requires addr[0]==0.
  - Word requires addr[1:0]==0.
  - bus_width==3 is always misaligned.
- RAM read:
  - Word index = addr[31:2].
  - Byte: rdata = {24'b0, lane addr[1:0]}.
  - Half: rdata = {16'b0, half addr[1]}.
  - Word: the full word.
  - The core performs sign extension itself.
- RAM write: places the low byte, half or word of bus_wdata in the lane selected by addr[1:0]. Byte-enable semantics apply; other lanes are unchanged.
- MMIO map, word access only:
  - +0x0 mtime[31:0], +0x4 mtime[63:32], +0x8 mtimecmp[31:0], +0xC mtimecmp[63:32], all read/write.
  - A byte or half access to MMIO is a fault.
- Faults: misaligned access, unmapped address, MMIO non-word access, and read_en and write_en both high.
  - Effect: no state change, bus_rdata=0 next cycle, bus_error=1 next cycle.
  - A cycle with neither enable set never faults.
- Timer:
  - The prescaler counts 0..TICK_DIV-1; mtime increments by 1 on the cycle the prescaler wraps.
  - mtime wraps from 2^64-1 to 0.
  - A bus write to either mtime half in the same cycle as an increment takes priority: the written half gets bus_wdata, and the other half is left unchanged with no increment that cycle.
- Interrupt: timer_irq <= (mtime >= mtimecmp), unsigned 64-bit compare, registered. It therefore reflects the register values of the previous cycle.
  - Writing mtimecmp above mtime deasserts timer_irq within 2 cycles.
- 64-bit reads are not atomic; software reads hi, then lo, then hi again.
- RAM is inferred as a synchronous single-port array of DEPTH x 32 with byte-lane writes.

Test Plan:
- Word write 0x00000000 to address 0x4, then byte write 0xAB to 0x5, then word read of 0x4 -> bus_rdata=0x0000AB00 one cycle after the read; a byte read of 0x5 -> 0x000000AB.
- Word write 0xDEADBEEF to 0x8, then half read of 0xA -> 0x0000DEAD; half read of 0x9 -> bus_rdata=0 and bus_error=1 for exactly one cycle, with RAM at 0x8 still 0xDEADBEEF.
- TICK_DIV=1, write mtimecmp_hi=0 and mtimecmp_lo=20 after reset -> timer_irq rises once mtime reaches 20, two cycles later at most. Then write mtimecmp_lo=0xFFFFFFFF -> timer_irq falls within 2 cycles.
- Write mtime_lo=0xFFFFFFFF and mtime_hi=0xFFFFFFFF, then idle -> mtime reads 0 and 0 after the wrap. Write mtime_lo=5 in a cycle where an increment is due -> a subsequent read shows 5 plus the elapsed cycles only.
- Assert read_en and write_en together on 0x10 with wdata 0x1234 -> bus_error=1 and RAM unchanged. Access MMIO_BASE+0x10, which is unmapped -> bus_error=1 and rdata=0.
- Assert reset mid-run with an outstanding write and the timer at 100 -> outputs are 0 immediately (asynchronously), mtime=0 and mtimecmp is all ones after release, and previously written RAM words are retained.

Source files
------------

// File: rtl/mem_responder.sv
// Memory-bus target: word RAM with byte lanes plus a memory-mapped machine timer (mtime/mtimecmp).
// Requests sampled on rising clk; rdata/error registered one cycle later; always ready, no backpressure.
module mem_responder #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF0000,
  parameter int          TICK_DIV  = 1,
  parameter              INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic        bus_read_en,
  input  logic        bus_write_en,
  input  logic [1:0]  bus_width,
  output logic [31:0] bus_rdata,
  output logic        bus_error,
  output logic        timer_irq
);

  localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);

  localparam logic [1:0] SRC_ZERO = 2'd0;
  localparam logic [1:0] SRC_RAM  = 2'd1;
  localparam logic [1:0] SRC_MMIO = 2'd2;

  logic [31:0] mem [DEPTH];

  logic [31:0]   mmio_off;
  logic          ram_hit, mmio_hit, ram_sel;
  logic          access, misaligned, fault, ok;
  logic          ram_we, ram_re, mmio_we, mmio_re;
  logic [AW-1:0] widx;
  logic [3:0]    be;
  logic [31:0]   wlane;
  logic [31:0]   mmio_rd;

  logic [31:0] ram_q;
  logic [31:0] mmio_q;
  logic [1:0]  rsrc;
  logic [1:0]  rwidth;
  logic [1:0]  roff;

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [31:0] pcnt;
  logic        tick;

  assign mmio_off = bus_addr - MMIO_BASE;
  assign ram_hit  = bus_addr[31:2] < 30'(DEPTH);
  assign mmio_hit = mmio_off < 32'd16;
  // MMIO window wins if it ever overlaps the RAM range.
  assign ram_sel  = ram_hit & ~mmio_hit;
  assign access   = bus_read_en | bus_write_en;
  assign widx     = bus_addr[AW+1:2];

  always_comb begin
    misaligned = 1'b0;
    case (bus_width)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = bus_addr[0];
      2'd2:    misaligned = |bus_addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  assign fault = access & ((bus_read_en & bus_write_en) | misaligned |
                           ~(ram_hit | mmio_hit) | (mmio_hit & (bus_width != 2'd2)));
  assign ok      = access & ~fault;
  assign ram_we  = ok & bus_write_en & ram_sel;
  assign ram_re  = ok & bus_read_en  & ram_sel;
  assign mmio_we = ok & bus_write_en & mmio_hit;
  assign mmio_re = ok & bus_read_en  & mmio_hit;

  always_comb begin
    be    = 4'b1111;
    wlane = bus_wdata;
    case (bus_width)
      2'd0: begin
        be    = 4'b0001 << bus_addr[1:0];
        wlane = {4{bus_wdata[7:0]}};
      end
      2'd1: begin
        be    = bus_addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{bus_wdata[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wlane = bus_wdata;
      end
    endcase
  end

  always_comb begin
    mmio_rd = 32'd0;
    case (mmio_off[3:2])
      2'd0:    mmio_rd = mtime[31:0];
      2'd1:    mmio_rd = mtime[63:32];
      2'd2:    mmio_rd = mtimecmp[31:0];
      default: mmio_rd = mtimecmp[63:32];
    endcase
  end

  // Plain synchronous array; a write is dropped if reset is low at the edge.
  always_ff @(posedge clk) begin
    if (ram_we && reset) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
    if (ram_re) ram_q <= mem[widx];
  end

  assign tick = (pcnt == TICK_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_error <= 1'b0;
      timer_irq <= 1'b0;
      rsrc      <= SRC_ZERO;
      rwidth    <= 2'd0;
      roff      <= 2'd0;
      mmio_q    <= 32'd0;
      mtime     <= 64'd0;
      mtimecmp  <= '1;
      pcnt      <= 32'd0;
    end else begin
      bus_error <= fault;
      if (fault) begin
        rsrc <= SRC_ZERO;
      end else if (ram_re) begin
        rsrc   <= SRC_RAM;
        rwidth <= bus_width;
        roff   <= bus_addr[1:0];
      end else if (mmio_re) begin
        rsrc   <= SRC_MMIO;
        mmio_q <= mmio_rd;
      end

      pcnt <= tick ? 32'd0 : pcnt + 32'd1;
      // A software write to either half suppresses that cycle's increment.
      if (mmio_we && mmio_off[3:2] == 2'd0)      mtime[31:0]  <= bus_wdata;
      else if (mmio_we && mmio_off[3:2] == 2'd1) mtime[63:32] <= bus_wdata;
      else if (tick)                             mtime        <= mtime + 64'd1;

      if (mmio_we && mmio_off[3:2] == 2'd2) mtimecmp[31:0]  <= bus_wdata;
      if (mmio_we && mmio_off[3:2] == 2'd3) mtimecmp[63:32] <= bus_wdata;

      timer_irq <= (mtime >= mtimecmp);
    end
  end

  // Lane extraction happens after the register so the array read stays a plain word read.
  always_comb begin
    bus_rdata = 32'd0;
    case (rsrc)
      SRC_RAM: begin
        case (rwidth)
          2'd0:    bus_rdata = {24'd0, ram_q[8*roff +: 8]};
          2'd1:    bus_rdata = {16'd0, ram_q[16*roff[1] +: 16]};
          default: bus_rdata = ram_q;
        endcase
      end
      SRC_MMIO: bus_rdata = mmio_q;
      default:  bus_rdata = 32'd0;
    endcase
  end

endmodule
